// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scan_pkg
//  Description : Shared encodings for the multi-chain scan engine: operation
//                modes, FSM states and word-packing helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

    // Operation mode, sampled at start.
    typedef enum logic [1:0] {
        MODE_SWAP = 2'b00,  // restore from t1, capture to t0
        MODE_DUMP = 2'b01,  // capture to t0, recirculate tail into head
        MODE_LOAD = 2'b10,  // restore from t1 only
        MODE_ZERO = 2'b11   // capture to t0, shift zeros in
    } scan_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_FLUSH = 2'b10,
        ST_DONE  = 2'b11
    } scan_state_e;

    // Shift steps held in one FIFO word.
    function automatic int shifts_per_word(input int data_w, input int num_chains);
        return data_w / num_chains;
    endfunction

    // Step counter width; never zero so a single-step word still has a legal vector.
    function automatic int step_width(input int s);
        return (s > 1) ? $clog2(s) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_lane_serdes.sv
`default_nettype none
// ============================================================================
//  Module      : scan_lane_serdes
//  Description : Per-step word slicing. Selects the NUM_CHAINS head bits of
//                the current step from the restore word, and packs captured
//                tail bits into a word that is handed off on the last step.
//  Ports       : clk_i/rst_ni    clock, async active-low reset
//                par_word_i      restore word being serialised
//                step_i          shift step within the current word
//                ser_bits_o      head bits for this step
//                cap_en_i        a shift happens this cycle (capture tails)
//                cap_last_i      this shift closes the word
//                cap_bits_i      chain tails
//                clear_i         discard the partially packed word
//                word_o          last completed capture word
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_lane_serdes
    import scan_pkg::*;
#(
    parameter int NUM_CHAINS = 4,
    parameter int DATA_W     = 32,
    parameter int STEP_W     = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_W-1:0]     par_word_i,
    input  logic [STEP_W-1:0]     step_i,
    output logic [NUM_CHAINS-1:0] ser_bits_o,
    input  logic                  cap_en_i,
    input  logic                  cap_last_i,
    input  logic [NUM_CHAINS-1:0] cap_bits_i,
    input  logic                  clear_i,
    output logic [DATA_W-1:0]     word_o
);

    localparam int S = shifts_per_word(DATA_W, NUM_CHAINS);

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] w_merged;

    always_comb begin
        ser_bits_o = '0;
        for (int k = 0; k < S; k++) begin
            if (step_i == STEP_W'(k)) begin
                ser_bits_o = par_word_i[k*NUM_CHAINS +: NUM_CHAINS];
            end
        end
    end

    // Accumulator with this step's tails dropped into their slot. Slots above
    // the current step are still zero, which gives the zero padding of a
    // short final word for free.
    for (genvar k = 0; k < S; k++) begin : g_slot
        assign w_merged[k*NUM_CHAINS +: NUM_CHAINS] =
            (step_i == STEP_W'(k)) ? cap_bits_i : acc_q[k*NUM_CHAINS +: NUM_CHAINS];
    end

    always_comb begin
        acc_d  = acc_q;
        word_d = word_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (cap_en_i) begin
            if (cap_last_i) begin
                word_d = w_merged;
                acc_d  = '0;
            end else begin
                acc_d  = w_merged;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            word_q <= '0;
        end else begin
            acc_q  <= acc_d;
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule
`default_nettype wire

// File: rtl/scan_multi_engine.sv
`default_nettype none
// ============================================================================
//  Module      : scan_multi_engine
//  Description : Drives NUM_CHAINS parallel scan chains between the t1 (read)
//                and t0 (write) FIFOs, with per-operation mode, abort and
//                busy/done/aborted status.
//  Ports       : aclk_i, aresetn_i            clock, async active-low reset
//                start_i, abort_i, mode_i,     operation control
//                length_i
//                busy_o, done_o, aborted_o     status
//                scan_output_i / scan_input_o  chain tails / heads
//                scan_enable_o, scan_ck_enable_o
//                rd_en_o, data_out_i, empty_i  t1 FIFO read side
//                wr_en_o, data_in_o,           t0 FIFO write side
//                almost_full_i
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_multi_engine
    import scan_pkg::*;
#(
    parameter int NUM_CHAINS = 4,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16
) (
    input  logic                  aclk_i,
    input  logic                  aresetn_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [1:0]            mode_i,
    input  logic [LEN_W-1:0]      length_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  aborted_o,
    input  logic [NUM_CHAINS-1:0] scan_output_i,
    output logic [NUM_CHAINS-1:0] scan_input_o,
    output logic                  scan_enable_o,
    output logic                  scan_ck_enable_o,
    output logic                  rd_en_o,
    input  logic [DATA_W-1:0]     data_out_i,
    input  logic                  empty_i,
    output logic                  wr_en_o,
    output logic [DATA_W-1:0]     data_in_o,
    input  logic                  almost_full_i
);

    localparam int S      = shifts_per_word(DATA_W, NUM_CHAINS);
    localparam int STEP_W = step_width(S);
    localparam int LOG2S  = $clog2(S);
    localparam int WCNT_W = LEN_W + 1;

    scan_state_e         state_q, state_d;
    scan_mode_e          mode_q, mode_d;
    logic [LEN_W-1:0]    shift_cnt_q, shift_cnt_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [WCNT_W-1:0]   rd_words_q, rd_words_d;
    logic [DATA_W-1:0]   in_word_q, in_word_d;
    logic                in_valid_q, in_valid_d;
    logic                rd_pending_q, rd_pending_d;
    logic                out_pending_q, out_pending_d;
    logic                aborted_q;

    logic                w_start, w_abort, w_use_in, w_use_out, w_in_avail;
    logic                w_ck_en, w_last, w_word_end, w_rd_en, w_wr_en;
    logic [WCNT_W-1:0]   w_words;
    logic [DATA_W-1:0]   w_in_word;
    logic [NUM_CHAINS-1:0] w_ser_bits;

    assign w_start    = (state_q == ST_IDLE) && start_i;
    assign w_abort    = abort_i && ((state_q == ST_SHIFT) || (state_q == ST_FLUSH));
    assign w_use_in   = (mode_q == MODE_SWAP) || (mode_q == MODE_LOAD);
    assign w_use_out  = (mode_q != MODE_LOAD);
    // A word returned by the FIFO this cycle is usable straight away, which
    // keeps the cost of each refill to the single rd_en cycle.
    assign w_in_avail = in_valid_q || rd_pending_q;
    assign w_in_word  = rd_pending_q ? data_out_i : in_word_q;
    assign w_words    = ({1'b0, length_i} + WCNT_W'(S - 1)) >> LOG2S;

    assign w_ck_en    = (state_q == ST_SHIFT) && !w_abort
                        && (!w_use_in || w_in_avail)
                        && (!w_use_out || !almost_full_i);
    assign w_last     = (shift_cnt_q == LEN_W'(1));
    assign w_word_end = (step_q == STEP_W'(S - 1)) || w_last;
    assign w_rd_en    = (state_q == ST_SHIFT) && w_use_in && !empty_i
                        && !in_valid_q && !rd_pending_q && (rd_words_q != '0);
    // Pending capture waits out almost_full; a shift cannot complete another
    // word meanwhile because shifts are gated on the same flag.
    assign w_wr_en    = out_pending_q && !almost_full_i && !w_abort;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = (length_i == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_abort) begin
                    state_d = ST_IDLE;
                end else if (w_ck_en && w_last) begin
                    state_d = w_use_out ? ST_FLUSH : ST_DONE;
                end
            end
            ST_FLUSH: begin
                if (w_abort) begin
                    state_d = ST_IDLE;
                end else if (w_wr_en) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ----------------------------------------------------- datapath / counters
    always_comb begin
        mode_d        = mode_q;
        shift_cnt_d   = shift_cnt_q;
        step_d        = step_q;
        rd_words_d    = rd_words_q;
        in_word_d     = in_word_q;
        in_valid_d    = in_valid_q;
        rd_pending_d  = w_rd_en;
        out_pending_d = out_pending_q;
        if (w_start) begin
            mode_d        = scan_mode_e'(mode_i);
            shift_cnt_d   = length_i;
            step_d        = '0;
            rd_words_d    = w_words;
            in_valid_d    = 1'b0;
            out_pending_d = 1'b0;
        end else if (w_abort) begin
            // Anything in flight, including a read issued now, is dropped.
            shift_cnt_d   = '0;
            rd_words_d    = '0;
            in_valid_d    = 1'b0;
            rd_pending_d  = 1'b0;
            out_pending_d = 1'b0;
        end else begin
            if (w_rd_en) begin
                rd_words_d = rd_words_q - WCNT_W'(1);
            end
            if (rd_pending_q) begin
                in_word_d  = data_out_i;
                in_valid_d = 1'b1;
            end
            if (w_ck_en) begin
                shift_cnt_d = shift_cnt_q - LEN_W'(1);
                step_d      = (step_q == STEP_W'(S - 1)) ? '0 : step_q + STEP_W'(1);
                if (w_word_end) begin
                    in_valid_d = 1'b0;
                end
            end
            if (w_wr_en) begin
                out_pending_d = 1'b0;
            end
            if (w_ck_en && w_word_end && w_use_out) begin
                out_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_SWAP;
            shift_cnt_q   <= '0;
            step_q        <= '0;
            rd_words_q    <= '0;
            in_word_q     <= '0;
            in_valid_q    <= 1'b0;
            rd_pending_q  <= 1'b0;
            out_pending_q <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            shift_cnt_q   <= shift_cnt_d;
            step_q        <= step_d;
            rd_words_q    <= rd_words_d;
            in_word_q     <= in_word_d;
            in_valid_q    <= in_valid_d;
            rd_pending_q  <= rd_pending_d;
            out_pending_q <= out_pending_d;
            aborted_q     <= w_abort;
        end
    end

    scan_lane_serdes #(
        .NUM_CHAINS (NUM_CHAINS),
        .DATA_W     (DATA_W),
        .STEP_W     (STEP_W)
    ) u_serdes (
        .clk_i      (aclk_i),
        .rst_ni     (aresetn_i),
        .par_word_i (w_in_word),
        .step_i     (step_q),
        .ser_bits_o (w_ser_bits),
        .cap_en_i   (w_ck_en && w_use_out),
        .cap_last_i (w_word_end),
        .cap_bits_i (scan_output_i),
        .clear_i    (w_start || w_abort),
        .word_o     (data_in_o)
    );

    always_comb begin
        scan_input_o = '0;
        if (state_q == ST_SHIFT) begin
            case (mode_q)
                MODE_SWAP, MODE_LOAD: scan_input_o = w_ser_bits;
                MODE_DUMP:            scan_input_o = scan_output_i;
                default:              scan_input_o = '0;
            endcase
        end
    end

    assign busy_o           = (state_q != ST_IDLE);
    assign done_o           = (state_q == ST_DONE);
    assign aborted_o        = aborted_q;
    assign scan_enable_o    = (state_q == ST_SHIFT) || (state_q == ST_FLUSH);
    assign scan_ck_enable_o = w_ck_en;
    assign rd_en_o          = w_rd_en;
    assign wr_en_o          = w_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_scan_multi_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_scan_multi_engine
//  Description : Bench for scan_multi_engine with FIFO and scan-chain models
//                and a transaction-level scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_multi_engine;

    localparam int NC     = 4;
    localparam int DW     = 32;
    localparam int LW     = 16;
    localparam int S      = DW / NC;
    localparam int CH_LEN = 10;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [LW-1:0] length = '0;
    logic          busy, done, aborted, scan_enable, scan_ck_enable, rd_en, wr_en;
    logic [NC-1:0] scan_output = '0;
    logic [NC-1:0] scan_input;
    logic [DW-1:0] data_out = '0;
    logic [DW-1:0] data_in;
    logic          empty = 1'b1;
    logic          almost_full = 1'b0;

    always #5 aclk = ~aclk;

    scan_multi_engine #(.NUM_CHAINS(NC), .DATA_W(DW), .LEN_W(LW)) dut (
        .aclk_i           (aclk),
        .aresetn_i        (aresetn),
        .start_i          (start),
        .abort_i          (abort),
        .mode_i           (mode),
        .length_i         (length),
        .busy_o           (busy),
        .done_o           (done),
        .aborted_o        (aborted),
        .scan_output_i    (scan_output),
        .scan_input_o     (scan_input),
        .scan_enable_o    (scan_enable),
        .scan_ck_enable_o (scan_ck_enable),
        .rd_en_o          (rd_en),
        .data_out_i       (data_out),
        .empty_i          (empty),
        .wr_en_o          (wr_en),
        .data_in_o        (data_in),
        .almost_full_i    (almost_full)
    );

    int chk = 0;
    int err = 0;

    logic [DW-1:0]     fifo[$];
    bit                force_empty = 1'b0;
    logic [CH_LEN-1:0] chain [NC];
    logic [CH_LEN-1:0] snap  [NC];
    logic [NC-1:0]     exp_in[$];
    logic [DW-1:0]     exp_out[$];
    logic [NC-1:0]     head_hist[$];
    logic [1:0]        m_mode = 2'b00;
    int                m_len = 0;
    int                shifts, rd_cnt, wr_cnt, done_cnt, ab_cnt, ck_af_cnt;
    logic [DW-1:0]     m_acc = '0;
    logic [DW-1:0]     last_wr = '0;
    bit                rd_seen = 1'b0;
    bit                ck_seen = 1'b0;
    logic [NC-1:0]     head_seen = '0;
    logic [NC-1:0]     mon_eh;

    function automatic bit use_in(input logic [1:0] m);
        return (m == 2'b00) || (m == 2'b10);
    endfunction

    function automatic bit use_out(input logic [1:0] m);
        return (m != 2'b10);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        chk++;
        if (act !== req) begin
            err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic update_pins();
        for (int c = 0; c < NC; c++) scan_output[c] = chain[c][CH_LEN-1];
        empty = force_empty || (fifo.size() == 0);
    endtask

    // Compare process: checks every cycle's outputs against the scoreboard.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (scan_ck_enable) begin
                check("ck_busy_sen", {scan_enable, busy}, 2'b11);
                if (use_out(m_mode)) check("ck_while_af", almost_full, 1'b0);
                if (almost_full) ck_af_cnt++;
                case (m_mode)
                    2'b00, 2'b10: begin
                        if (exp_in.size() == 0) begin
                            check("extra_shift", exp_in.size(), 1);
                            mon_eh = '0;
                        end else begin
                            mon_eh = exp_in.pop_front();
                        end
                    end
                    2'b01:   mon_eh = scan_output;
                    default: mon_eh = '0;
                endcase
                check("scan_input", scan_input, mon_eh);
                head_hist.push_back(scan_input);
                head_seen = scan_input;
                ck_seen   = 1'b1;
                if (use_out(m_mode)) m_acc[(shifts % S)*NC +: NC] = scan_output;
                shifts++;
                if (use_out(m_mode) && ((shifts % S == 0) || (shifts == m_len))) begin
                    exp_out.push_back(m_acc);
                    m_acc = '0;
                end
            end
            if (wr_en) begin
                check("wr_while_af", almost_full, 1'b0);
                wr_cnt++;
                last_wr = data_in;
                if (exp_out.size() == 0) check("wr_unexpected", exp_out.size(), 1);
                else                     check("data_in", data_in, exp_out.pop_front());
            end
            if (rd_en) begin
                rd_cnt++;
                rd_seen = 1'b1;
            end
            if (done) begin
                done_cnt++;
                check("done_outs", {scan_enable, scan_ck_enable, wr_en}, 3'b000);
            end
            if (aborted) begin
                ab_cnt++;
                check("abort_outs", {scan_enable, scan_ck_enable, busy, done, wr_en}, 5'b00000);
            end
        end
    end

    // One clock: FIFO pop and chain shift take effect just after the edge.
    task automatic tick();
        @(posedge aclk);
        #1;
        if (rd_seen && fifo.size() > 0) data_out = fifo.pop_front();
        if (ck_seen) begin
            for (int c = 0; c < NC; c++) chain[c] = {chain[c][CH_LEN-2:0], head_seen[c]};
        end
        rd_seen = 1'b0;
        ck_seen = 1'b0;
        update_pins();
    endtask

    task automatic start_op(input logic [1:0] m, input int len);
        exp_in.delete();
        exp_out.delete();
        head_hist.delete();
        if (use_in(m)) begin
            for (int k = 0; k < len; k++) begin
                logic [DW-1:0] w;
                w = fifo[k / S];
                exp_in.push_back(w[(k % S)*NC +: NC]);
            end
        end
        m_mode = m; m_len = len; shifts = 0; rd_cnt = 0; wr_cnt = 0;
        done_cnt = 0; ab_cnt = 0; ck_af_cnt = 0; m_acc = '0;
        mode = m; length = LW'(len); start = 1'b1;
        tick();
        start = 1'b0;
        if (len != 0) check("busy_after_start", busy, 1'b1);
        check("sen_after_start", scan_enable, (len != 0));
    endtask

    task automatic wait_end(input bit stress, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && ab_cnt == 0 && n < budget) begin
            if (stress) begin
                almost_full = ($urandom_range(0, 3) == 0);
                force_empty = ($urandom_range(0, 4) == 0);
                update_pins();
            end
            tick();
            n++;
        end
        almost_full = 1'b0; force_empty = 1'b0;
        update_pins();
        check("op_timeout", (n < budget), 1'b1);
    endtask

    task automatic wait_shifts(input int target);
        int n;
        n = 0;
        while (shifts < target && n < 200) begin
            tick();
            n++;
        end
        check("shift_wait_timeout", (n < 200), 1'b1);
    endtask

    task automatic end_check();
        int words;
        words = (m_len + S - 1) / S;
        check("done_once",   done_cnt, 1);
        check("shift_total", shifts, m_len);
        check("rd_total",    rd_cnt, use_in(m_mode) ? words : 0);
        check("wr_total",    wr_cnt, use_out(m_mode) ? words : 0);
        check("in_left",     exp_in.size(), 0);
        check("out_left",    exp_out.size(), 0);
        check("idle_after",  {busy, scan_enable}, 2'b00);
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) fifo.push_back($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        int         m, len;
        for (int c = 0; c < NC; c++) chain[c] = '0;
        update_pins();

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_ctrl", {busy, done, aborted, scan_enable, scan_ck_enable, rd_en, wr_en}, 7'b0);
        check("rst_data", {scan_input, data_in}, '0);
        aresetn = 1'b1;
        tick(); tick();

        // Swap with constant 0xA tails
        pat = 4'hA;
        for (int c = 0; c < NC; c++) chain[c] = {CH_LEN{pat[c]}};
        fifo.push_back(32'h7654_3210);
        update_pins();
        start_op(2'b00, 8);
        wait_end(1'b0, 200);
        end_check();
        for (int k = 0; k < 8; k++) check("t1_head_seq", head_hist[k], k);
        check("t1_word", last_wr, 32'hAAAA_AAAA);

        // Non-destructive dump of a full chain
        for (int c = 0; c < NC; c++) begin
            chain[c] = CH_LEN'($urandom);
            snap[c]  = chain[c];
        end
        update_pins();
        start_op(2'b01, 10);
        wait_end(1'b0, 200);
        end_check();
        for (int c = 0; c < NC; c++) check("t2_chain_kept", chain[c], snap[c]);
        check("t2_pad", last_wr[31:8], 24'h0);

        // Back-pressure window from shift 4
        push_words(2);
        update_pins();
        start_op(2'b00, 16);
        wait_shifts(4);
        almost_full = 1'b1;
        repeat (5) tick();
        almost_full = 1'b0;
        check("t3_no_shift_in_af", ck_af_cnt, 0);
        wait_end(1'b0, 300);
        end_check();

        // Load-only with a starved FIFO
        push_words(1);
        force_empty = 1'b1;
        update_pins();
        start_op(2'b10, 8);
        repeat (6) tick();
        check("t4_no_shift", shifts, 0);
        check("t4_no_rd", rd_cnt, 0);
        force_empty = 1'b0;
        update_pins();
        wait_end(1'b0, 200);
        end_check();

        // Abort at shift 3, then a fresh short operation
        push_words(2);
        update_pins();
        start_op(2'b00, 16);
        wait_shifts(3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("t5_aborted", ab_cnt, 1);
        check("t5_no_done", done_cnt, 0);
        check("t5_idle", {busy, scan_enable}, 2'b00);
        fifo.delete();
        push_words(1);
        update_pins();
        start_op(2'b00, 4);
        wait_end(1'b0, 200);
        end_check();

        // Zero length
        start_op(2'b00, 0);
        tick();
        check("t6_done_next", done_cnt, 1);
        wait_end(1'b0, 10);
        end_check();

        // Start pulse while busy is ignored
        push_words(2);
        update_pins();
        start_op(2'b00, 16);
        wait_shifts(5);
        mode = 2'b01; length = LW'(3); start = 1'b1;
        tick();
        start = 1'b0;
        wait_end(1'b0, 300);
        end_check();

        // Randomised operations with random stalls
        for (int r = 0; r < 14; r++) begin
            m   = $urandom_range(0, 3);
            len = $urandom_range(1, 40);
            for (int c = 0; c < NC; c++) chain[c] = CH_LEN'($urandom);
            fifo.delete();
            if (use_in(2'(m))) push_words((len + S - 1) / S);
            update_pins();
            start_op(2'(m), len);
            wait_end(1'b1, 3000);
            end_check();
        end

        // Reset in the middle of an operation
        start_op(2'b01, 20);
        repeat (3) tick();
        aresetn = 1'b0;
        #1;
        check("midrst_ctrl", {busy, done, aborted, scan_enable, scan_ck_enable, rd_en, wr_en}, 7'b0);
        check("midrst_data", {scan_input, data_in}, '0);
        tick();
        aresetn = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
`default_nettype wire
